conv1d_mac_engine: RTL

//   Parametrised successor to the single-filter convolution MAC top level. Streams a 1-D signed

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_coef_bank.sv | 41 ++++
 rtl/conv1d_mac_engine.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types, default parameters and width helpers for the 1-D convolution MAC engine.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    MAC,
    OUT,
    SHIFT,
    DONE
  } convState;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_COEF_W   = 8;
  localparam int DEF_TAPS     = 16;
  localparam int DEF_NUM_FILT = 4;
  localparam int DEF_LEN_W    = 10;

  // Product width plus enough guard bits to sum TAPS full-scale products.
  function automatic int accWidth(input int dataW, input int coefW, input int taps);
    return dataW + coefW + $clog2(taps);
  endfunction

  // Index width that never collapses to zero bits for a single-entry dimension.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_coef_bank.sv
// NUM_FILT x TAPS coefficient register file: one synchronous write port, one
// combinational read port addressed by (filter, tap).
module conv_coef_bank
  import conv_pkg::*;
#(
  parameter int COEF_W   = DEF_COEF_W,
  parameter int TAPS     = DEF_TAPS,
  parameter int NUM_FILT = DEF_NUM_FILT,
  parameter int TAP_W    = idxWidth(TAPS),
  parameter int FILT_W   = idxWidth(NUM_FILT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [FILT_W-1:0]        wrFilt,
  input  logic [TAP_W-1:0]         wrTap,
  input  logic [COEF_W-1:0]        wrData,
  input  logic [FILT_W-1:0]        rdFilt,
  input  logic [TAP_W-1:0]         rdTap,
  output logic signed [COEF_W-1:0] rdData
);

  logic signed [COEF_W-1:0] mem [NUM_FILT][TAPS];

  // NOTE: this array is flop-based and must come up cleared, so it is reset
  // explicitly; a RAM macro could not be reset this way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < NUM_FILT; f++) begin
        for (int t = 0; t < TAPS; t++) begin
          mem[f][t] <= '0;
        end
      end
    end else if (we) begin
      mem[wrFilt][wrTap] <= $signed(wrData);
    end
  end

  assign rdData = mem[rdFilt][rdTap];

endmodule

// File: rtl/conv1d_mac_engine.sv
// Streaming 1-D convolution: TAPS-deep sliding window, NUM_FILT coefficient sets,
// configurable stride and optional ReLU, one multiply-accumulate per cycle.
module conv1d_mac_engine
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int TAPS     = DEF_TAPS,
  parameter int NUM_FILT = DEF_NUM_FILT,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int ACC_W    = accWidth(DATA_W, COEF_W, TAPS),
  parameter int TAP_W    = idxWidth(TAPS),
  parameter int FILT_W   = idxWidth(NUM_FILT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [2:0]        cfg_stride,
  input  logic              cfg_relu,
  input  logic              coef_we,
  input  logic [FILT_W-1:0] coef_filt,
  input  logic [TAP_W-1:0]  coef_tap,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [FILT_W-1:0] out_filt,
  output logic              ready,
  output logic              done,
  output logic              err_len
);

  localparam int PROD_W = DATA_W + COEF_W;

  convState                 state;
  logic signed [DATA_W-1:0] win [TAPS];
  logic signed [COEF_W-1:0] coefRd;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  accBase;
  logic signed [ACC_W-1:0]  accSum;

  logic [TAP_W-1:0]  tapIdx;
  logic [FILT_W-1:0] filtIdx;
  logic [LEN_W-1:0]  remCnt;
  logic [LEN_W-1:0]  sampleCnt;
  logic [LEN_W-1:0]  strideLen;
  logic [2:0]        strideReg;
  logic              reluReg;

  logic              readyReg;
  logic              inReadyReg;
  logic              outValidReg;
  logic              doneReg;
  logic              errLenReg;
  logic [ACC_W-1:0]  outDataReg;
  logic [FILT_W-1:0] outFiltReg;

  logic sampleAccept;
  logic coefWe;
  logic lastTap;
  logic lastFilt;
  logic lenShort;

  assign sampleAccept = in_valid && inReadyReg;
  assign coefWe       = coef_we && (state == IDLE);
  assign lastTap      = (tapIdx == TAP_W'(TAPS - 1));
  assign lastFilt     = (filtIdx == FILT_W'(NUM_FILT - 1));
  assign lenShort     = (cfg_len < LEN_W'(TAPS));
  assign strideLen    = LEN_W'(strideReg);

  conv_coef_bank #(
    .COEF_W  (COEF_W),
    .TAPS    (TAPS),
    .NUM_FILT(NUM_FILT),
    .TAP_W   (TAP_W),
    .FILT_W  (FILT_W)
  ) u_coef_bank (
    .clk   (clk),
    .reset (reset),
    .we    (coefWe),
    .wrFilt(coef_filt),
    .wrTap (coef_tap),
    .wrData(coef_data),
    .rdFilt(filtIdx),
    .rdTap (tapIdx),
    .rdData(coefRd)
  );

  // NOTE: every always_comb output is assigned on every path, so no latch can
  // be inferred here.
  always_comb begin
    prod    = PROD_W'(win[tapIdx]) * PROD_W'(coefRd);
    accBase = (tapIdx == '0) ? '0 : acc;
    accSum  = accBase + ACC_W'(prod);
  end

  // win[0] holds the oldest sample; new samples enter at the top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        win[i] <= '0;
      end
    end else if (sampleAccept) begin
      for (int i = 0; i < TAPS - 1; i++) begin
        win[i] <= win[i + 1];
      end
      win[TAPS - 1] <= $signed(in_data);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      readyReg    <= 1'b1;
      inReadyReg  <= 1'b0;
      outValidReg <= 1'b0;
      doneReg     <= 1'b0;
      errLenReg   <= 1'b0;
      outDataReg  <= '0;
      outFiltReg  <= '0;
      acc         <= '0;
      tapIdx      <= '0;
      filtIdx     <= '0;
      remCnt      <= '0;
      sampleCnt   <= '0;
      strideReg   <= 3'd1;
      reluReg     <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            readyReg  <= 1'b0;
            errLenReg <= lenShort;
            strideReg <= (cfg_stride == 3'd0) ? 3'd1 : cfg_stride;
            reluReg   <= cfg_relu;
            remCnt    <= cfg_len;
            sampleCnt <= LEN_W'(TAPS);
            if (lenShort) begin
              state   <= DONE;
              doneReg <= 1'b1;
            end else begin
              state      <= FILL;
              inReadyReg <= 1'b1;
            end
          end
        end

        FILL, SHIFT: begin
          if (sampleAccept) begin
            remCnt    <= remCnt - LEN_W'(1);
            sampleCnt <= sampleCnt - LEN_W'(1);
            if (sampleCnt == LEN_W'(1)) begin
              state      <= MAC;
              inReadyReg <= 1'b0;
              tapIdx     <= '0;
              filtIdx    <= '0;
            end
          end
        end

        MAC: begin
          acc <= accSum;
          if (lastTap) begin
            state       <= OUT;
            outValidReg <= 1'b1;
            outDataReg  <= (reluReg && accSum[ACC_W-1]) ? '0 : accSum;
            outFiltReg  <= filtIdx;
          end else begin
            tapIdx <= tapIdx + TAP_W'(1);
          end
        end

        OUT: begin
          if (out_ready) begin
            outValidReg <= 1'b0;
            tapIdx      <= '0;
            if (!lastFilt) begin
              filtIdx <= filtIdx + FILT_W'(1);
              state   <= MAC;
            end else if (remCnt >= strideLen) begin
              state      <= SHIFT;
              inReadyReg <= 1'b1;
              sampleCnt  <= strideLen;
            end else begin
              state   <= DONE;
              doneReg <= 1'b1;
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          readyReg <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          readyReg    <= 1'b1;
          inReadyReg  <= 1'b0;
          outValidReg <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = readyReg;
  assign in_ready  = inReadyReg;
  assign out_valid = outValidReg;
  assign out_data  = outDataReg;
  assign out_filt  = outFiltReg;
  assign done      = doneReg;
  assign err_len   = errLenReg;

endmodule
